// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive path.
//   rx_state_t  : receive FSM state encoding
//   calc_parity : XOR-reduce of up to 9 data bits, optionally inverted (odd)
// Narrower data words are zero-extended by the caller; zeros do not change
// the XOR.
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_t;

  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter, 0 .. CLKS_PER_BIT-1, with explicit wrap.
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   clr       in  hold/force count to 0
//   mid_tick  out count == CLKS_PER_BIT/2-1 (half a bit after clear)
//   full_tick out count == CLKS_PER_BIT-1   (one bit after clear / wrap)
// ---------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic mid_tick,
  output logic full_tick
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  logic [TW-1:0] cnt_q, cnt_d;

  assign mid_tick  = (cnt_q == TW'(CLKS_PER_BIT/2 - 1));
  assign full_tick = (cnt_q == TW'(CLKS_PER_BIT - 1));

  // Wrap is an explicit compare so non-power-of-two periods work.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || full_tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
// UART receive deframer fed by the synchronized RX line. Validates the start
// bit at mid-bit, samples data LSB-first at bit centres, checks the stop bit
// and hands bytes out on a valid/ready interface.
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   rx_sync     in  synchronized serial line, idle high
//   rx_data     out received word (DATA_BITS)
//   rx_valid    out rx_data holds an unconsumed word
//   rx_ready    in  consumer accepts the word
//   busy        out frame reception in progress
//   frame_err   out pulse: stop bit sampled 0
//   overrun_err out pulse: good word completed while previous still held
//   parity_err  out pulse: parity mismatch (0 unless UART_RX_PARITY_EN)
// Optional feature macro: UART_RX_PARITY_EN inserts a parity bit after data.
// ---------------------------------------------------------------------------
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_sync,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int IW = $clog2(DATA_BITS);

  rx_state_t            state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;       // stop bit sampled last cycle
  logic                 stop_ok_q, stop_ok_d;
  logic                 par_bad_q, par_bad_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 perr_q, perr_d;
  logic                 tmr_clr, mid_tick, full_tick;
  logic                 good, xfer;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr),
    .mid_tick  (mid_tick),
    .full_tick (full_tick)
  );

  // ---------------- frame FSM ----------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    done_d    = 1'b0;
    stop_ok_d = stop_ok_q;
    par_bad_d = par_bad_q;
    tmr_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (!rx_sync) state_d = START;
      end
      START: begin
        if (mid_tick) begin
          // Timer restarts here so every later tick lands on a bit centre.
          tmr_clr = 1'b1;
          if (!rx_sync) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (full_tick) begin
          sh_d  = {rx_sync, sh_q[DATA_BITS-1:1]};
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (full_tick) begin
          par_bad_d = (rx_sync != calc_parity(9'(sh_q), PARITY_ODD != 0));
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (full_tick) begin
          done_d    = 1'b1;
          stop_ok_d = rx_sync;
          state_d   = rx_sync ? IDLE : BREAK_WAIT;
        end
      end
      BREAK_WAIT: begin
        // A held-low break must see the line return high before a new START.
        tmr_clr = 1'b1;
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef UART_RX_PARITY_EN
  // Parity is not checked in this build; keep the parameter referenced.
  logic unused_par;
  assign unused_par = calc_parity(9'(sh_q), PARITY_ODD != 0);
`endif

  // ---------------- output / handshake stage ----------------
  assign xfer = valid_q && rx_ready;
  assign good = done_q && stop_ok_q && !par_bad_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q && !xfer;
    oerr_d  = 1'b0;
    ferr_d  = done_q && !stop_ok_q;
    perr_d  = done_q && par_bad_q;
    if (good) begin
      // A word may load only into an empty or draining holding register.
      if (!valid_q || xfer) begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end else begin
        oerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      stop_ok_q <= 1'b0;
      par_bad_q <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      stop_ok_q <= stop_ok_d;
      par_bad_q <= par_bad_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
      perr_q    <= perr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign parity_err  = perr_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
module tb_uart_rx_deframer;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Falling edge seen -> rx_valid visible.
  localparam int LAT = CPB/2 + (DB + 1 + PB)*CPB + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_sync = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, busy, frame_err, overrun_err, parity_err;

  uart_rx_deframer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(PODD)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_sync     (rx_sync),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [DB-1:0] exp_q[$];
  int n_ferr = 0, n_oerr = 0, n_perr = 0;
  int e_ferr = 0, e_oerr = 0, e_perr = 0;
  int t_fall = 0, t_rise = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word, tallies pulses.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rx_valid && !prev_valid) t_rise = cyc;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", rx_data);
        end else begin
          chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err)   n_ferr++;
      if (overrun_err) n_oerr++;
      if (parity_err)  n_perr++;
    end
    prev_valid = rx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_sync = b;
    repeat (CPB) tick();
  endtask

  function automatic logic par_of(input logic [DB-1:0] d);
    return (^d) ^ (PODD != 0);
  endfunction

  // Reference model: a frame is good iff stop is 1 (and parity matches when
  // enabled). A good word is delivered if the consumer can take it, else it
  // is an overrun.
  task automatic frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b,
                       input logic can_take);
    logic good;
    good = stop_b;
`ifdef UART_RX_PARITY_EN
    if (par_b != par_of(d)) begin
      good = 1'b0;
      e_perr++;
    end
`endif
    if (!stop_b) e_ferr++;
    if (good) begin
      if (can_take) exp_q.push_back(d);
      else          e_oerr++;
    end
    t_fall = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`endif
    send_bit(stop_b);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_ferr_cnt"}, n_ferr, e_ferr);
    chk({tag, "_oerr_cnt"}, n_oerr, e_oerr);
    chk({tag, "_perr_cnt"}, n_perr, e_perr);
  endtask

  initial begin
    int bc;
    logic [DB-1:0] d;
    logic stp, par;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun_err", overrun_err, 0);
    chk("rst_parity_err", parity_err, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Basic frame with latency
    frame(8'hA5, 1'b1, par_of(8'hA5), 1'b1);
    chk("latency", t_rise - t_fall, LAT);
    chk("busy_after_frame", busy, 0);
    chk_counts("a5");

    // Start-bit glitch rejection
    bc = 0;
    for (int i = 0; i < 24; i++) begin
      rx_sync = (i < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) bc++;
      tick();
    end
    chk("glitch_busy_1to8", (bc >= 1 && bc <= 8), 1);
    chk("glitch_no_valid", rx_valid, 0);

    // Framing error followed by held break
    frame(8'h3C, 1'b0, par_of(8'h3C), 1'b1);
    repeat (40) tick();
    @(negedge clk);
    chk("break_busy", busy, 1);
    chk_counts("break");
    tick();
    rx_sync = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("break_release_busy", busy, 0);
    tick();
    frame(8'h5A, 1'b1, par_of(8'h5A), 1'b1);

    // Overrun: two words with consumer stalled
    rx_ready = 1'b0;
    frame(8'h11, 1'b1, par_of(8'h11), 1'b1);
    frame(8'h22, 1'b1, par_of(8'h22), 1'b0);
    repeat (2) tick();
    @(negedge clk);
    chk("ovr_valid_held", rx_valid, 1);
    chk("ovr_data_held", 32'(rx_data), 32'h11);
    chk_counts("ovr");
    tick();
    rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ovr_valid_drop", rx_valid, 0);
    tick();

    // Reset mid-frame
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mrst_rx_data", 32'(rx_data), 0);
    chk("mrst_rx_valid", rx_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_errs", {frame_err, overrun_err, parity_err}, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    frame(8'h7E, 1'b1, par_of(8'h7E), 1'b1);
    chk_counts("mrst");

`ifdef UART_RX_PARITY_EN
    // Parity mismatch then match
    frame(8'h03, 1'b1, 1'b1, 1'b1);
    frame(8'h03, 1'b1, 1'b0, 1'b1);
    chk_counts("par");
`endif

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      d   = DB'($urandom);
      stp = ($urandom_range(0, 9) != 0);
      par = par_of(d) ^ ($urandom_range(0, 9) == 0);
      frame(d, stp, par, 1'b1);
      if (!stp) begin
        rx_sync = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
      end else begin
        repeat ($urandom_range(0, 3)) tick();
      end
    end

    // Drain, bounded
    rx_sync = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk_counts("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
